// File: rtl/crc32_stream.sv
//==============================================================================
// Module   : crc32_stream
// Purpose  : Frame-aware CRC-32 engine (poly 04C11DB7, MSB-first) with
//            valid/ready in, held valid/ready result out and a byte count.
// Options  : define CRC32_RESIDUE_CHECK_EN to add the out_ok residue flag.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module crc32_stream #(
    parameter int          DATA_W = 32,
    parameter logic [31:0] INIT   = 32'hFFFFFFFF,
    localparam int         BW     = ((DATA_W / 8) > 1) ? $clog2(DATA_W / 8) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [BW-1:0]     in_bytes,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_crc,
    output logic [15:0]       out_len,
`ifdef CRC32_RESIDUE_CHECK_EN
    output logic              out_ok,
`endif
    output logic              err
);

    localparam logic [31:0] C_POLY   = 32'h04C11DB7;
    localparam logic [4:0]  C_NBYTES = 5'(DATA_W / 8);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [31:0]  r_acc;
    logic [15:0]  r_cnt;
    logic [31:0]  r_out_crc;
    logic [15:0]  r_out_len;
    logic         r_err;
`ifdef CRC32_RESIDUE_CHECK_EN
    logic         r_ok;
`endif

    logic         w_accept;
    logic         w_take;
    logic         w_in_frame;
    logic         w_process;
    logic         w_frame_err;
    logic [4:0]   w_bytes_in;
    logic [4:0]   w_nbytes;
    logic [31:0]  w_crc_base;
    logic [31:0]  w_crc_next;
    logic [15:0]  w_cnt_base;
    logic [16:0]  w_cnt_sum;
    logic [15:0]  w_cnt_next;

    // Bytes at index >= nbytes (counted from the MSB) are left out of the CRC.
    function automatic logic [31:0] crc_update(
        input logic [31:0]       crc_in,
        input logic [DATA_W-1:0] data,
        input logic [4:0]        nbytes
    );
        logic [31:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 0; i < DATA_W / 8; i++) begin
            if (5'(i) < nbytes) begin
                for (int j = 0; j < 8; j++) begin
                    fb = c[31] ^ data[DATA_W - 1 - 8 * i - j];
                    c  = {c[30:0], 1'b0} ^ (fb ? C_POLY : 32'h0);
                end
            end
        end
        return c;
    endfunction

    assign in_ready  = (r_state != S_HOLD) || out_ready;
    assign out_valid = (r_state == S_HOLD);
    assign out_crc   = r_out_crc;
    assign out_len   = r_out_len;
    assign err       = r_err;
`ifdef CRC32_RESIDUE_CHECK_EN
    assign out_ok    = r_ok;
`endif

    // A result taken this cycle makes the engine behave as IDLE for the incoming beat.
    always_comb begin
        w_accept    = in_valid && in_ready;
        w_take      = (r_state == S_HOLD) && out_ready;
        w_in_frame  = (r_state == S_BUSY);
        w_process   = w_accept && (in_sop || w_in_frame);
        w_frame_err = w_accept && (in_sop ? w_in_frame : !w_in_frame);

        w_state_next = w_take ? S_IDLE : r_state;
        if (w_process) begin
            w_state_next = in_eop ? S_HOLD : S_BUSY;
        end
    end

    always_comb begin
        w_bytes_in = 5'(in_bytes);
        w_nbytes   = C_NBYTES;
        if (in_eop && (w_bytes_in != 5'd0) && (w_bytes_in <= C_NBYTES)) begin
            w_nbytes = w_bytes_in;
        end

        w_crc_base = in_sop ? INIT : r_acc;
        w_crc_next = crc_update(w_crc_base, in_data, w_nbytes);

        w_cnt_base = in_sop ? 16'd0 : r_cnt;
        w_cnt_sum  = {1'b0, w_cnt_base} + 17'(w_nbytes);
        w_cnt_next = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc     <= INIT;
            r_cnt     <= 16'd0;
            r_out_crc <= 32'd0;
            r_out_len <= 16'd0;
            r_err     <= 1'b0;
`ifdef CRC32_RESIDUE_CHECK_EN
            r_ok      <= 1'b0;
`endif
        end else begin
            r_err <= w_frame_err;
            if (w_process) begin
                r_acc <= w_crc_next;
                r_cnt <= w_cnt_next;
                if (in_eop) begin
                    r_out_crc <= w_crc_next;
                    r_out_len <= w_cnt_next;
`ifdef CRC32_RESIDUE_CHECK_EN
                    r_ok      <= (w_crc_next == 32'h0);
`endif
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_crc32_stream.sv
//==============================================================================
// Module   : tb_crc32_stream
// Purpose  : Self-checking bench for crc32_stream against a byte-queue CRC model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_crc32_stream;

    localparam int DW = 32;
    localparam int NB = DW / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_sop = 1'b0;
    logic          in_eop = 1'b0;
    logic [BW-1:0] in_bytes = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_crc;
    logic [15:0]   out_len;
    logic          out_ok;
    logic          err;

    always #5 clk = ~clk;

    crc32_stream #(.DATA_W(DW), .INIT(32'hFFFFFFFF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sop   (in_sop),
        .in_eop   (in_eop),
        .in_bytes (in_bytes),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_crc  (out_crc),
        .out_len  (out_len),
`ifdef CRC32_RESIDUE_CHECK_EN
        .out_ok   (out_ok),
`endif
        .err      (err)
    );
`ifndef CRC32_RESIDUE_CHECK_EN
    assign out_ok = 1'b0;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          err_cnt  = 0;
    int          cyc      = 0;
    logic [7:0]  frm[$];
    logic [31:0] q_crc[$];
    logic [15:0] q_len[$];
    logic        q_ok[$];
    logic [31:0] e_crc[$];
    logic [15:0] e_len[$];

    always @(posedge clk) cyc++;

    // Observe handshakes at the falling edge, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                q_crc.push_back(out_crc);
                q_len.push_back(out_len);
                q_ok.push_back(out_ok);
            end
            if (err) err_cnt++;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_crc();
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (frm[k]) begin
            for (int j = 7; j >= 0; j--) begin
                if (c[31] ^ frm[k][j]) c = (c << 1) ^ 32'h04C11DB7;
                else                   c = c << 1;
            end
        end
        return c;
    endfunction

    function automatic logic [15:0] ref_len();
        return (frm.size() > 65535) ? 16'hFFFF : 16'(frm.size());
    endfunction

    function automatic logic [DW-1:0] beat_word(input int start);
        logic [DW-1:0] w = '0;
        for (int i = 0; i < NB; i++)
            if (start + i < frm.size()) w[DW - 1 - 8 * i -: 8] = frm[start + i];
        return w;
    endfunction

    task automatic make_frame(input int len);
        frm.delete();
        for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
    endtask

    task automatic make_check_string();
        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
    endtask

    task automatic clear_queues();
        q_crc.delete(); q_len.delete(); q_ok.delete();
        e_crc.delete(); e_len.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic drive_beat(input logic [DW-1:0] d, input logic s, input logic e,
                              input logic [BW-1:0] b);
        int t = 0;
        in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e; in_bytes = b;
        @(negedge clk);
        while (!in_ready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL beat_timeout: in_ready got 0 expected 1 within 200 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic send_frame(input int first_beat, input bit gaps);
        int nbeats = (frm.size() + NB - 1) / NB;
        for (int b = first_beat; b < nbeats; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            drive_beat(beat_word(b * NB), b == 0, b == nbeats - 1, BW'(frm.size() % NB));
        end
    endtask

    task automatic wait_results(input int n, output bit timed_out);
        int t = 0;
        while (q_crc.size() < n && t < 200) begin @(negedge clk); t++; end
        timed_out = (q_crc.size() < n);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_crc !== 32'h0) begin n_fail++; $display("FAIL reset_out_crc: got %h expected 00000000", out_crc); end
        n_checks++; if (out_len !== 16'h0) begin n_fail++; $display("FAIL reset_out_len: got %h expected 0000", out_len); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        @(posedge clk); #1;
    endtask

    task automatic test_known();
        bit to;
        int e0 = err_cnt;
        clear_queues();
        make_check_string();
        send_frame(0, 0);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL known_latency: out_valid got %b expected 1", out_valid); end
        wait_results(1, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL known_result: got no result expected 1"); end
        else begin
            n_checks++; if (q_crc[0] !== 32'h0376E6E7) begin n_fail++; $display("FAIL known_crc: got %h expected 0376e6e7", q_crc[0]); end
            n_checks++; if (q_len[0] !== 16'd9) begin n_fail++; $display("FAIL known_len: got %0d expected 9", q_len[0]); end
        end
        n_checks++; if (err_cnt !== e0) begin n_fail++; $display("FAIL known_err: got %0d expected %0d", err_cnt, e0); end
    endtask

    task automatic test_random();
        bit to;
        clear_queues();
        for (int f = 0; f < 25; f++) begin
            make_frame($urandom_range(1, 3 * NB + 5));
            e_crc.push_back(ref_crc()); e_len.push_back(ref_len());
            send_frame(0, 1);
        end
        wait_results(25, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL random_count: got %0d expected 25", q_crc.size()); end
        else begin
            for (int i = 0; i < 25; i++) begin
                n_checks++; if (q_crc[i] !== e_crc[i]) begin n_fail++; $display("FAIL random_crc[%0d]: got %h expected %h", i, q_crc[i], e_crc[i]); end
                n_checks++; if (q_len[i] !== e_len[i]) begin n_fail++; $display("FAIL random_len[%0d]: got %0d expected %0d", i, q_len[i], e_len[i]); end
`ifdef CRC32_RESIDUE_CHECK_EN
                n_checks++; if (q_ok[i] !== (e_crc[i] == 32'h0)) begin n_fail++; $display("FAIL random_ok[%0d]: got %b expected %b", i, q_ok[i], e_crc[i] == 32'h0); end
`endif
            end
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int c0;
        clear_queues();
        c0 = cyc;
        for (int f = 0; f < 8; f++) begin
            make_frame($urandom_range(1, NB));
            e_crc.push_back(ref_crc()); e_len.push_back(ref_len());
            send_frame(0, 0);
        end
        n_checks++; if (cyc - c0 !== 8) begin n_fail++; $display("FAIL b2b_cycles: got %0d expected 8", cyc - c0); end
        wait_results(8, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", q_crc.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++; if (q_crc[i] !== e_crc[i]) begin n_fail++; $display("FAIL b2b_crc[%0d]: got %h expected %h", i, q_crc[i], e_crc[i]); end
                n_checks++; if (q_len[i] !== e_len[i]) begin n_fail++; $display("FAIL b2b_len[%0d]: got %0d expected %0d", i, q_len[i], e_len[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        logic [31:0] a_crc, b_crc;
        logic [15:0] a_len, b_len;
        clear_queues();
        out_ready = 1'b0;
        make_frame(2 * NB + 3);
        a_crc = ref_crc(); a_len = ref_len();
        send_frame(0, 0);
        make_frame(2 * NB + 2);
        b_crc = ref_crc(); b_len = ref_len();
        in_valid = 1'b1; in_data = beat_word(0); in_sop = 1'b1; in_eop = 1'b0; in_bytes = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", k, out_valid); end
            n_checks++; if (out_crc !== a_crc) begin n_fail++; $display("FAIL bp_crc[%0d]: got %h expected %h", k, out_crc, a_crc); end
            n_checks++; if (out_len !== a_len) begin n_fail++; $display("FAIL bp_len[%0d]: got %0d expected %0d", k, out_len, a_len); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", k, in_ready); end
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: in_ready got %b expected 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; in_sop = 1'b0;
        send_frame(1, 0);
        wait_results(2, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL bp_count: got %0d expected 2", q_crc.size()); end
        else begin
            n_checks++; if (q_crc[0] !== a_crc) begin n_fail++; $display("FAIL bp_a_crc: got %h expected %h", q_crc[0], a_crc); end
            n_checks++; if (q_crc[1] !== b_crc) begin n_fail++; $display("FAIL bp_b_crc: got %h expected %h", q_crc[1], b_crc); end
            n_checks++; if (q_len[1] !== b_len) begin n_fail++; $display("FAIL bp_b_len: got %0d expected %0d", q_len[1], b_len); end
        end
    endtask

    task automatic test_framing();
        bit to;
        int e0 = err_cnt;
        clear_queues();
        drive_beat(DW'($urandom), 1'b0, 1'b1, '0);
        @(negedge clk);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL frm_orphan_err: got %b expected 1", err); end
        @(negedge clk);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL frm_orphan_pulse: got %b expected 0", err); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL frm_orphan_valid: got %b expected 0", out_valid); end
        repeat (2) @(negedge clk);
        n_checks++; if (q_crc.size() !== 0) begin n_fail++; $display("FAIL frm_orphan_result: got %0d expected 0", q_crc.size()); end
        n_checks++; if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL frm_orphan_count: got %0d expected %0d", err_cnt, e0 + 1); end
        @(posedge clk); #1;
        make_frame(3 * NB);
        drive_beat(beat_word(0), 1'b1, 1'b0, '0);
        drive_beat(beat_word(NB), 1'b0, 1'b0, '0);
        make_frame($urandom_range(NB + 1, 3 * NB));
        send_frame(0, 0);
        wait_results(1, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL frm_restart_count: got %0d expected 1", q_crc.size()); end
        else begin
            n_checks++; if (q_crc[0] !== ref_crc()) begin n_fail++; $display("FAIL frm_restart_crc: got %h expected %h", q_crc[0], ref_crc()); end
            n_checks++; if (q_len[0] !== ref_len()) begin n_fail++; $display("FAIL frm_restart_len: got %0d expected %0d", q_len[0], ref_len()); end
        end
        n_checks++; if (err_cnt !== e0 + 2) begin n_fail++; $display("FAIL frm_restart_err: got %0d expected %0d", err_cnt, e0 + 2); end
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_queues();
        make_frame(3 * NB);
        drive_beat(beat_word(0), 1'b1, 1'b0, '0);
        drive_beat(beat_word(NB), 1'b0, 1'b0, '0);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_len !== 16'h0) begin n_fail++; $display("FAIL rmid_len: got %0d expected 0", out_len); end
        n_checks++; if (out_crc !== 32'h0) begin n_fail++; $display("FAIL rmid_crc: got %h expected 00000000", out_crc); end
        @(posedge clk); #1;
        make_check_string();
        send_frame(0, 0);
        wait_results(1, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL rmid_count: got %0d expected 1", q_crc.size()); end
        else begin
            n_checks++; if (q_crc[0] !== 32'h0376E6E7) begin n_fail++; $display("FAIL rmid_after_crc: got %h expected 0376e6e7", q_crc[0]); end
            n_checks++; if (q_len[0] !== 16'd9) begin n_fail++; $display("FAIL rmid_after_len: got %0d expected 9", q_len[0]); end
        end
    endtask

    task automatic test_residue();
        bit to;
        logic [31:0] flip_crc;
        clear_queues();
        make_check_string();
        frm.push_back(8'h03); frm.push_back(8'h76); frm.push_back(8'hE6); frm.push_back(8'hE7);
        send_frame(0, 0);
        frm[2] = frm[2] ^ 8'h10;
        flip_crc = ref_crc();
        send_frame(0, 0);
        wait_results(2, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL res_count: got %0d expected 2", q_crc.size()); end
        else begin
            n_checks++; if (q_crc[0] !== 32'h0) begin n_fail++; $display("FAIL res_crc: got %h expected 00000000", q_crc[0]); end
            n_checks++; if (q_len[0] !== 16'd13) begin n_fail++; $display("FAIL res_len: got %0d expected 13", q_len[0]); end
            n_checks++; if (q_crc[1] !== flip_crc) begin n_fail++; $display("FAIL res_flip_crc: got %h expected %h", q_crc[1], flip_crc); end
`ifdef CRC32_RESIDUE_CHECK_EN
            n_checks++; if (q_ok[0] !== 1'b1) begin n_fail++; $display("FAIL res_ok: got %b expected 1", q_ok[0]); end
            n_checks++; if (q_ok[1] !== 1'b0) begin n_fail++; $display("FAIL res_flip_ok: got %b expected 0", q_ok[1]); end
`endif
        end
    endtask

    task automatic test_saturation();
        bit to;
        clear_queues();
        make_frame(65540);
        send_frame(0, 0);
        wait_results(1, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL sat_count: got %0d expected 1", q_crc.size()); end
        else begin
            n_checks++; if (q_len[0] !== 16'hFFFF) begin n_fail++; $display("FAIL sat_len: got %h expected ffff", q_len[0]); end
            n_checks++; if (q_crc[0] !== ref_crc()) begin n_fail++; $display("FAIL sat_crc: got %h expected %h", q_crc[0], ref_crc()); end
        end
    endtask

    initial begin
        test_reset();
        test_known();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_framing();
        test_reset_mid();
        test_residue();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
